brush_plotter: RTL
==================

# brush_plotter

Consumes the cursor position produced by the movement controller and turns it into a stream of single-pixel write strobes for the VGA frame-buffer adapter, painting a square brush whose top-left corner is the cursor. It sits between movement control and the VGA adapter in the paint top level. One pixel is emitted per clock, with a start/busy/done handshake toward the controller.

## Interface
Parameters:
- BRUSH, 4: brush edge length in pixels (1..8)
- MAX_X, 160: frame width; pixels with x >= MAX_X are never written
- MAX_Y, 120: frame height; pixels with y >= MAX_Y are never written

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request to paint one brush stamp; sampled only in IDLE
- inX  in  10  cursor x (top-left of brush)
- inY  in  10  cursor y (top-left of brush)
- colour  in  3  RGB colour for the stamp
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the stamp completes
- plot  out  1  write enable to the VGA adapter
- plotX  out  10  pixel x for the current write
- plotY  out  10  pixel y for the current write
- plotColour  out  3  pixel colour for the current write

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if start=1, latch inX, inY, colour into baseX, baseY, col; clear dx=dy=0; go to DRAW. Otherwise stay.
- DRAW: each cycle present the pixel (baseX+dx, baseY+dy), drive plotColour=col, and advance in row-major order: dx increments; when dx=BRUSH-1 it wraps to 0 and dy increments. After the pixel (BRUSH-1, BRUSH-1) go to DONE.
- Clipping: plot=1 only if baseX+dx < MAX_X and baseY+dy < MAX_Y. Clipped pixels still consume their cycle, with plot=0. Compute the sums at 11 bits so they never wrap. plotX and plotY are the low 10 bits.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in DRAW and DONE. It is not queued.
- inX, inY and colour may change freely after the accepting edge. Only latched values are used.
- A stamp always takes BRUSH*BRUSH DRAW cycles, regardless of clipping.

## Timing
- Reset values: state=IDLE, busy=0, done=0, plot=0, plotX=0, plotY=0, plotColour=0, dx=dy=0.
- Reset asserted mid-DRAW forces IDLE asynchronously. plot drops immediately and no further pixels are emitted.
- All outputs are registered.
- Cycle numbering: start is sampled high at edge 0.
  - The first pixel (dx=0, dy=0) is valid after edge 1.
  - Pixel k (k = dy*BRUSH + dx) is valid after edge k+1.
  - done is high after edge BRUSH*BRUSH+1, for one cycle.
  - IDLE is re-entered after edge BRUSH*BRUSH+2. A start there is accepted, giving back-to-back stamps every BRUSH*BRUSH+2 cycles.
- busy = (state != IDLE). It is high for BRUSH*BRUSH+1 cycles per stamp.
- plot, plotX, plotY and plotColour are mutually consistent in every cycle. The VGA adapter writes on any edge where plot=1.
- When start and reset are asserted together, reset wins.

## Test plan
- Reset, then start with inX=10, inY=20, colour=3'b100, BRUSH=4: 16 plot pulses, in order (10,20),(11,20)…(13,20),(10,21)…(13,23), all colour 100. done is high exactly at cycle 17 and busy is high during cycles 1–17.
- Corner clip, inX=158, inY=118, BRUSH=4:
  - Plot pulses only at x∈{158,159} and y∈{118,119}, i.e. 4 pulses.
  - The other 12 cycles have plot=0.
  - done still arrives at cycle 17.
- Input stability and ignored start: change inX, inY and colour every cycle during DRAW and hold start=1 throughout. All pixels use the latched values, and no second stamp starts until IDLE. If start is still high in the IDLE cycle, the next stamp begins there, 18 cycles after the first.
- Reset mid-stamp: assert reset at pixel 5. All outputs go to 0 immediately and the block stays in IDLE after release. A new start at (0,0) then produces a full 16-pixel stamp from (0,0).
- BRUSH=1 instance with inX=0, inY=0: a single plot pulse at cycle 1 and done at cycle 2.
- Out-of-range origin, inX=500, inY=5: no plot pulses at all, and done at cycle 17.

Source files
------------

// File: rtl/brush_plotter.sv
// ---------------------------------------------------------------------------
// brush_plotter
//
// Turns a cursor position into a stream of single-pixel write strobes for the
// VGA frame-buffer adapter. It paints a BRUSH x BRUSH square whose top-left
// corner is the cursor. One pixel is emitted per clock. Pixels that fall
// outside the MAX_X x MAX_Y frame still use up their cycle, but plot stays low
// for them.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high; clears all state
//   start       in   request one brush stamp (sampled only when idle)
//   inX, inY    in   [9:0] cursor position (top-left of the brush)
//   colour      in   [2:0] RGB colour for the stamp
//   busy        out  high from the cycle after an accepted start through done
//   done        out  one-cycle pulse when the stamp completes
//   plot        out  write enable to the VGA adapter
//   plotX/Y     out  [9:0] pixel coordinate for the current write
//   plotColour  out  [2:0] pixel colour for the current write
//
// All outputs are registered. The internal state runs one cycle ahead of the
// outputs: in DRAW it computes the pixel that becomes visible after the next
// edge. The busy and done outputs therefore show the externally visible
// phase, not the internal state.
// ---------------------------------------------------------------------------
module brush_plotter #(
    parameter int BRUSH = 4,
    parameter int MAX_X = 160,
    parameter int MAX_Y = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] inX,
    input  logic [9:0] inY,
    input  logic [2:0] colour,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [9:0] plotX,
    output logic [9:0] plotY,
    output logic [2:0] plotColour
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t     state;
    logic [9:0] base_x;
    logic [9:0] base_y;
    logic [2:0] col;
    logic [2:0] dx;     // BRUSH is at most 8, so 3 bits always suffice
    logic [2:0] dy;

    // The sums are 11 bits wide, so an origin near 1023 cannot wrap back
    // into the visible frame.
    logic [10:0] px;
    logic [10:0] py;
    logic        last_col;
    logic        last_row;

    assign px       = {1'b0, base_x} + {8'd0, dx};
    assign py       = {1'b0, base_y} + {8'd0, dy};
    assign last_col = (dx == 3'(BRUSH - 1));
    assign last_row = (dy == 3'(BRUSH - 1));

    // NOTE: all state and outputs are updated with non-blocking assignments,
    // so every register samples values from before the edge. Blocking
    // assignments here would make the result depend on statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_x     <= '0;
            base_y     <= '0;
            col        <= '0;
            dx         <= '0;
            dy         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            plotX      <= '0;
            plotY      <= '0;
            plotColour <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    plot <= 1'b0;
                    if (start) begin
                        base_x <= inX;
                        base_y <= inY;
                        col    <= colour;
                        dx     <= '0;
                        dy     <= '0;
                        state  <= DRAW;
                    end
                end

                DRAW: begin
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    plotX      <= px[9:0];
                    plotY      <= py[9:0];
                    plotColour <= col;
                    plot       <= (px < 11'(MAX_X)) && (py < 11'(MAX_Y));
                    // Row-major walk: x runs fastest, then y.
                    if (last_col) begin
                        dx <= '0;
                        dy <= dy + 3'd1;
                        if (last_row) begin
                            state <= DONE;
                        end
                    end else begin
                        dx <= dx + 3'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b1;
                    done  <= 1'b1;
                    plot  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
